// File: rtl/lc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared types and constants for the LC-3 memory responder.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   lc3_word_t : one 16-bit LC-3 word
//   *_ADDR     : memory-mapped I/O register addresses. The keyboard addresses
//                are reserved here for the keyboard block and are not decoded
//                by the responder.
// -----------------------------------------------------------------------------
package lc3_mem_pkg;

    typedef logic [15:0] lc3_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam lc3_word_t KBSR_ADDR = 16'hFE00;
    localparam lc3_word_t KBDR_ADDR = 16'hFE02;
    localparam lc3_word_t DSR_ADDR  = 16'hFE04;
    localparam lc3_word_t DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/lc3_display_port.sv
// -----------------------------------------------------------------------------
// lc3_display_port
// Display data register (DDR) and status (DSR ready bit) for the LC-3 display.
// A character written to DDR is held pending until the consumer acknowledges.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en       : one-cycle commit of a DDR write (asserted on the edge that
//                 ends the responder's RESP state)
//   wr_data     : character to load
//   ack         : display consumed the pending character
//   disp_valid  : character pending
//   disp_data   : pending character
//   dsr_ready   : DSR ready bit (display can take a new character)
// -----------------------------------------------------------------------------
module lc3_display_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ack,
    output logic       disp_valid,
    output logic [7:0] disp_data,
    output logic       dsr_ready
);

    // A write lands if nothing is pending, or if the pending character is
    // being consumed on this very edge; otherwise it is dropped.
    logic wr_accept;
    assign wr_accept = wr_en && (!disp_valid || ack);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else if (wr_accept) begin
            disp_valid <= 1'b1;
            disp_data  <= wr_data;
        end else if (disp_valid && ack) begin
            disp_valid <= 1'b0;
        end
    end

    assign dsr_ready = ~disp_valid;

endmodule

// File: rtl/lc3_mem_responder.sv
// -----------------------------------------------------------------------------
// lc3_mem_responder
// Memory-side responder for the LC-3 memory request interface. Accepts a
// request, waits WAIT_CYCLES, then gives a one-cycle rsp_ready pulse.
// Backs a 2**ADDR_W x 16 RAM and the display MMIO registers DSR/DDR.
//
// Handshake: the core raises req_valid with we/addr/wdata; the request is
// accepted on the first rising edge in IDLE where req_valid=1, and the request
// fields are latched there. rsp_ready is high for exactly one cycle, WAIT_CYCLES+1
// cycles after the accept edge; rsp_rdata is valid in that cycle. The core must
// drop req_valid in the cycle after rsp_ready, otherwise a new request starts.
//
// Parameters:
//   ADDR_W      : RAM address width (RAM depth 2**ADDR_W words), < 16
//   WAIT_CYCLES : wait states between accept and response, 0..15
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/we/addr/wdata : request from the core
//   rsp_ready, rsp_rdata : response pulse and read data
//   disp_valid/data/ack  : display consumer handshake
//   fsm_state            : current FSM state (debug observation)
//   rsp_err              : only with LC3_MEM_OOR_ERR_EN defined; high with
//                          rsp_ready for unmapped addresses or DSR writes
// -----------------------------------------------------------------------------
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack,
    output logic [1:0]  fsm_state
`ifdef LC3_MEM_OOR_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int        DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        lat_we;
    lc3_word_t   lat_addr;
    lc3_word_t   lat_wdata;
    lc3_word_t   rdata_q;
    lc3_word_t   rd_val;
    lc3_word_t   mem [DEPTH];

    logic        accept;
    logic        in_resp;
    logic        ram_hit;
    logic        dsr_hit;
    logic        ddr_hit;
    logic        dsr_ready;
    logic        ddr_wr;
    logic [ADDR_W-1:0] ram_idx;

    assign accept  = (state == IDLE) && req_valid;
    assign in_resp = (state == RESP);

    // ---------------- FSM state register and request latches ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= WAIT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    // ---------------- Address decode on the latched address ----------------
    assign ram_hit = ((lat_addr >> ADDR_W) == 16'd0);
    assign dsr_hit = (lat_addr == DSR_ADDR);
    assign ddr_hit = (lat_addr == DDR_ADDR);
    assign ram_idx = lat_addr[ADDR_W-1:0];

    always_comb begin
        rd_val = '0;
        if (ram_hit) begin
            rd_val = mem[ram_idx];
        end else if (dsr_hit) begin
            rd_val = {dsr_ready, 15'b0};
        end else if (ddr_hit) begin
            rd_val = {8'h00, disp_data};
        end
    end

    // Writes commit on the edge that ends RESP. Gating on rst_n keeps a reset
    // asserted in RESP from committing the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && in_resp && lat_we && ram_hit) begin
            mem[ram_idx] <= lat_wdata;
        end
    end

    // Read data shown during RESP; outside RESP the last read value is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (in_resp && !lat_we) begin
            rdata_q <= rd_val;
        end
    end

    assign rsp_ready = in_resp;
    assign rsp_rdata = in_resp ? (lat_we ? 16'h0000 : rd_val) : rdata_q;

`ifdef LC3_MEM_OOR_ERR_EN
    assign rsp_err = in_resp && ((!ram_hit && !dsr_hit && !ddr_hit) || (dsr_hit && lat_we));
`endif

    // ---------------- Display registers ----------------
    assign ddr_wr = in_resp && lat_we && ddr_hit;

    lc3_display_port u_disp (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (ddr_wr),
        .wr_data    (lat_wdata[7:0]),
        .ack        (disp_ack),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .dsr_ready  (dsr_ready)
    );

endmodule
